ofs_plat_prim_ram_rd_arb: RTL and testbench
===========================================

Name: ofs_plat_prim_ram_rd_arb

Overview:
- Shared-read-port controller wrapped around one ofs_plat_prim_ram_simple instance.
- Clears the RAM to INIT_VALUE after reset.
- Arbitrates N_READERS read requesters round-robin onto the single RAM read port and returns each response to its owner at a fixed latency.
- Gates the single write port until initialization completes.
- Used for shared lookup tables, e.g. tag/state memories read by several channel engines.

Parameters:
- N_ENTRIES, 32, RAM depth (>=2); AW = $clog2(N_ENTRIES).
- N_DATA_BITS, 64, entry width.
- N_READERS, 4, requester count (>=1); IW = max(1,$clog2(N_READERS)).
- N_OUTPUT_REG_STAGES, 0, passed to RAM; read latency LAT = 1 + N_OUTPUT_REG_STAGES.
- BYPASS_WRITES, 0, passed to RAM BYPASS_FULL_PIPELINE.
- INIT_VALUE, 0, value written to every entry during init.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rdy  out  1  init complete; stays high until next reset.
- wen  in  1  write enable; honoured only when rdy=1.
- waddr  in  AW  write address.
- wdata  in  N_DATA_BITS  write data.
- rd_req  in  N_READERS  per-requester read request (level; held until granted).
- rd_addr  in  N_READERS*AW  packed read addresses; requester i at [i*AW +: AW].
- rd_grant  out  N_READERS  one-hot, combinational; request accepted this cycle.
- rsp_valid  out  N_READERS  one-hot; response for requester i on rsp_data.
- rsp_data  out  N_DATA_BITS  shared response data.

Behaviour:
- Reset (async assert): state=INIT, init_addr=0, rr_ptr=0, all LAT in-flight valid bits 0, rdy=0. rsp_valid=0 and rd_grant=0 while in reset. RAM contents are not reset.
- FSM INIT:
  - Each cycle drives RAM write with addr=init_addr, data=INIT_VALUE, and increments init_addr.
  - External wen is ignored (dropped, not queued). rd_grant=0.
  - After the write to N_ENTRIES-1 the FSM moves to RUN; rdy=1 from the next cycle.
  - Exactly N_ENTRIES init write cycles occur, so rdy rises on the (N_ENTRIES+1)th rising edge after reset release.
- FSM RUN: terminal until reset. RAM write port = wen/waddr/wdata passthrough.
- Arbitration (RUN only):
  - Search order is rr_ptr, rr_ptr+1, ... mod N_READERS; first requester with rd_req=1 gets rd_grant.
  - At most one grant per cycle. The granted address drives the RAM raddr that cycle.
  - On a grant to i: rr_ptr <= (i+1) mod N_READERS. With no grant, rr_ptr holds.
  - Starvation bound: an asserted request is granted within N_READERS cycles.
- Response pipeline:
  - Shift register of LAT entries {valid, idx}. A grant at cycle T produces rsp_valid[idx]=1 at T+LAT with the RAM rdata.
  - Full throughput: one response per cycle. No backpressure; requesters must accept responses.
  - When nothing is valid: rsp_valid=0 and rsp_data is don't-care.
- Read/write hazards:
  - BYPASS_WRITES=0: a read granted in the same cycle as a write to the same address returns old data. A write in cycle T makes reads granted at T+1 or later return new data.
  - BYPASS_WRITES=1: writes in the grant cycle and in later in-flight cycles (except the final return cycle) are forwarded, per RAM semantics.
- N_READERS=1: the grant equals rd_req & rdy; rr_ptr is unused.
- Reset mid-operation: in-flight responses are discarded (never delivered), rdy drops immediately, and a full re-init follows.
- rd_grant depends combinationally on rd_req, rr_ptr and state. There is no combinational path from rd_grant back to rd_req.

Test Plan (N_ENTRIES=16, N_DATA_BITS=32, N_READERS=3, N_OUTPUT_REG_STAGES=1 so LAT=2, INIT_VALUE=32'hA5A5_0000):
1. Release reset, hold wen=1 waddr=3 wdata=1 during init, then read all 16 addresses via requester 0 -> rdy rises on the 17th edge; every read returns 32'hA5A5_0000 (the init-time write was dropped); rsp_valid[0] appears 2 cycles after each grant.
2. Write addr 5 = 32'h1234_5678; rd_req=3'b111 continuously, all to addr 5, for 6 cycles -> grant sequence 0,1,2,0,1,2; rsp_valid one-hot in the same order offset by 2 cycles; all data 32'h1234_5678.
3. Requesters 1 and 2 only, rr_ptr=0 -> grant 1 then 2 then 1; requester 0 asserts mid-stream and is granted within 3 cycles.
4. Same cycle: wen addr 7 = 32'hDEAD_BEEF and read addr 7 (BYPASS_WRITES=0) -> response is 32'hA5A5_0000. A read the next cycle returns 32'hDEAD_BEEF. Repeat with BYPASS_WRITES=1 -> both reads return 32'hDEAD_BEEF.
5. Grant a read, then assert reset asynchronously (mid-cycle) one cycle later -> rsp_valid stays 0, rdy drops immediately, rd_grant=0; after release, re-init takes 16 cycles and addr 7 reads back 32'hA5A5_0000.
6. Random rd_req/rd_addr/wen for 10k cycles against a reference memory model -> every response matches the model, rd_grant is one-hot or zero, and wait times are never more than 3 cycles.

Source files
------------

// File: rtl/ofs_plat_prim_ram_rd_arb.sv
// Shared-read-port RAM controller: clears the RAM after reset, then arbitrates
// several read requesters round-robin onto one read port and returns each
// response to its owner after the fixed RAM read latency.

// Simple dual-port RAM: one write port and one read port. Read latency is
// 1 + N_OUTPUT_REG_STAGES. With BYPASS_FULL_PIPELINE set, a write to the
// address being read is forwarded into the read pipeline from the read
// cycle up to, but not including, the cycle the data is returned.
module ofs_plat_prim_ram_simple #(
    parameter int N_ENTRIES = 32,
    parameter int N_DATA_BITS = 64,
    parameter int N_OUTPUT_REG_STAGES = 0,
    parameter int BYPASS_FULL_PIPELINE = 0
) (
    input  logic                         clk,
    input  logic                         wen,
    input  logic [$clog2(N_ENTRIES)-1:0] waddr,
    input  logic [N_DATA_BITS-1:0]       wdata,
    input  logic [$clog2(N_ENTRIES)-1:0] raddr,
    output logic [N_DATA_BITS-1:0]       rdata
);
    localparam int AW = $clog2(N_ENTRIES);
    localparam int LAT = 1 + N_OUTPUT_REG_STAGES;

    logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
    logic [N_DATA_BITS-1:0] data_q [LAT];
    logic [AW-1:0]          addr_q [LAT];

    // Storage write and read pipeline; each stage may pick up a write to its address.
    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
        data_q[0] <= ((BYPASS_FULL_PIPELINE != 0) && wen && (waddr == raddr)) ? wdata : mem[raddr];
        addr_q[0] <= raddr;
        for (int j = 1; j < LAT; j++) begin
            data_q[j] <= ((BYPASS_FULL_PIPELINE != 0) && wen && (waddr == addr_q[j-1])) ?
                         wdata : data_q[j-1];
            addr_q[j] <= addr_q[j-1];
        end
    end

    assign rdata = data_q[LAT-1];
endmodule

// States:
//   state    | meaning
//   ST_INIT  | writing INIT_VALUE to every entry, reads and external writes blocked
//   ST_RUN   | initialization done; rdy follows one cycle later and stays high
module ofs_plat_prim_ram_rd_arb #(
    parameter int N_ENTRIES = 32,
    parameter int N_DATA_BITS = 64,
    parameter int N_READERS = 4,
    parameter int N_OUTPUT_REG_STAGES = 0,
    parameter int BYPASS_WRITES = 0,
    parameter logic [N_DATA_BITS-1:0] INIT_VALUE = '0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    output logic                                   rdy,
    input  logic                                   wen,
    input  logic [$clog2(N_ENTRIES)-1:0]           waddr,
    input  logic [N_DATA_BITS-1:0]                 wdata,
    input  logic [N_READERS-1:0]                   rd_req,
    input  logic [N_READERS*$clog2(N_ENTRIES)-1:0] rd_addr,
    output logic [N_READERS-1:0]                   rd_grant,
    output logic [N_READERS-1:0]                   rsp_valid,
    output logic [N_DATA_BITS-1:0]                 rsp_data
);
    localparam int AW = $clog2(N_ENTRIES);
    localparam int IW = (N_READERS > 1) ? $clog2(N_READERS) : 1;
    localparam int LAT = 1 + N_OUTPUT_REG_STAGES;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state;
    logic [AW-1:0]        init_addr;
    logic [IW-1:0]        rr_ptr;
    logic                 grant_any;
    logic [IW-1:0]        grant_idx;
    logic [LAT-1:0]       pipe_valid;
    logic [IW-1:0]        pipe_idx [LAT];
    logic [AW-1:0]        req_addr [N_READERS];

    logic                 ram_wen;
    logic [AW-1:0]        ram_waddr;
    logic [N_DATA_BITS-1:0] ram_wdata;
    logic [AW-1:0]        ram_raddr;
    logic [N_DATA_BITS-1:0] ram_rdata;

    for (genvar i = 0; i < N_READERS; i++) begin : g_addr
        assign req_addr[i] = rd_addr[i*AW +: AW];
    end

    // Init sweep and ready flag; RUN is terminal until the next reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            init_addr <= '0;
            rdy       <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (init_addr == AW'(N_ENTRIES - 1)) state <= ST_RUN;
                end
                ST_RUN: rdy <= 1'b1;
                default: state <= ST_INIT;
            endcase
        end
    end

    // Round-robin search starting at rr_ptr; only while ready.
    always_comb begin
        logic [IW-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (rdy) begin
            for (int k = 0; k < N_READERS; k++) begin
                cand = IW'((int'(rr_ptr) + k) % N_READERS);
                if (!grant_any && rd_req[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign rd_grant  = grant_any ? (N_READERS'(1) << grant_idx) : '0;
    assign ram_raddr = req_addr[grant_idx];

    // Priority moves to the requester after the one just granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (int'(grant_idx) == N_READERS - 1) ? '0 : grant_idx + IW'(1);
        end
    end

    // Owner tracking for reads in flight, aligned with the RAM latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int j = 0; j < LAT; j++) pipe_idx[j] <= '0;
        end else begin
            pipe_valid[0] <= grant_any;
            pipe_idx[0]   <= grant_idx;
            for (int j = 1; j < LAT; j++) begin
                pipe_valid[j] <= pipe_valid[j-1];
                pipe_idx[j]   <= pipe_idx[j-1];
            end
        end
    end

    assign rsp_valid = pipe_valid[LAT-1] ? (N_READERS'(1) << pipe_idx[LAT-1]) : '0;
    assign rsp_data  = ram_rdata;

    // The init sweep owns the write port; afterwards external writes pass only once ready.
    assign ram_wen   = (state == ST_INIT) || (rdy && wen);
    assign ram_waddr = (state == ST_INIT) ? init_addr : waddr;
    assign ram_wdata = (state == ST_INIT) ? INIT_VALUE : wdata;

    ofs_plat_prim_ram_simple #(
        .N_ENTRIES(N_ENTRIES),
        .N_DATA_BITS(N_DATA_BITS),
        .N_OUTPUT_REG_STAGES(N_OUTPUT_REG_STAGES),
        .BYPASS_FULL_PIPELINE(BYPASS_WRITES)
    ) ram (
        .clk(clk),
        .wen(ram_wen),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(ram_raddr),
        .rdata(ram_rdata)
    );
endmodule

// File: tb/tb_ofs_plat_prim_ram_rd_arb.sv
// Bench for ofs_plat_prim_ram_rd_arb: 16 entries, 32 bits, 3 readers, latency 2.
// Two instances share stimulus; one without and one with write bypass.
module tb_ofs_plat_prim_ram_rd_arb;
    localparam int NE = 16;
    localparam int DW = 32;
    localparam int NR = 3;
    localparam int AW = 4;
    localparam logic [31:0] INIT = 32'hA5A5_0000;
    localparam logic [31:0] D1 = 32'h1234_5678;

    logic clk = 1'b0;
    logic reset;
    logic rdy, rdy_b;
    logic wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [NR-1:0] rd_req;
    logic [NR*AW-1:0] rd_addr;
    logic [NR-1:0] rd_grant, rd_grant_b;
    logic [NR-1:0] rsp_valid, rsp_valid_b;
    logic [DW-1:0] rsp_data, rsp_data_b;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ofs_plat_prim_ram_rd_arb #(
        .N_ENTRIES(NE), .N_DATA_BITS(DW), .N_READERS(NR),
        .N_OUTPUT_REG_STAGES(1), .BYPASS_WRITES(0), .INIT_VALUE(INIT)
    ) dut (
        .clk(clk), .reset(reset), .rdy(rdy), .wen(wen), .waddr(waddr), .wdata(wdata),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    ofs_plat_prim_ram_rd_arb #(
        .N_ENTRIES(NE), .N_DATA_BITS(DW), .N_READERS(NR),
        .N_OUTPUT_REG_STAGES(1), .BYPASS_WRITES(1), .INIT_VALUE(INIT)
    ) dut_b (
        .clk(clk), .reset(reset), .rdy(rdy_b), .wen(wen), .waddr(waddr), .wdata(wdata),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b)
    );

    typedef struct {
        logic [2:0]  req;
        logic [3:0]  a0, a1, a2;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [2:0]  exp_g;
        logic [2:0]  exp_v;
        logic [31:0] exp_d;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(logic [2:0] req, logic [3:0] a0, logic [3:0] a1, logic [3:0] a2,
                                logic we, logic [3:0] wa, logic [31:0] wd,
                                logic [2:0] eg, logic [2:0] ev, logic [31:0] ed);
        vec_t v;
        v.req = req; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.we = we; v.wa = wa; v.wd = wd;
        v.exp_g = eg; v.exp_v = ev; v.exp_d = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, sample grant and responses, advance.
    task automatic cyc(input logic [2:0] req, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [3:0] a2, input logic we, input logic [3:0] wa,
                       input logic [31:0] wd, output logic [2:0] g, output logic [2:0] rv,
                       output logic [31:0] rd, output logic [2:0] rvb, output logic [31:0] rdb);
        rd_req = req;
        rd_addr = {a2, a1, a0};
        wen = we;
        waddr = wa;
        wdata = wd;
        #1;
        g = rd_grant;
        rv = rsp_valid;
        rd = rsp_data;
        rvb = rsp_valid_b;
        rdb = rsp_data_b;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input string name);
        int got;
        logic bad;
        got = 0;
        bad = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (rdy && rdy_b) begin
                got = e;
                break;
            end
            if (rd_grant != 0 || rd_grant_b != 0) bad = 1'b1;
        end
        chk({name, "_rdy_edge"}, got, 17);
        chk({name, "_grant_during_init"}, {31'd0, bad}, 0);
    endtask

    logic [2:0]  g, rv, rvb;
    logic [31:0] rd, rdb;
    logic [31:0] ref_mem [NE];
    logic [2:0]  rq, eg;
    logic [3:0]  ra [NR];
    int          wcnt [NR];
    int          mptr, ewin, cand;
    logic        we_r;
    logic [3:0]  wa_r;
    logic [31:0] wd_r;
    logic        pv [2];
    logic [1:0]  pidx [2];
    logic [31:0] pd [2];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(3'b000, 0, 0, 0, 1, 5, D1, 3'b000, 3'b000, 0);
        tbl[1]  = mk(3'b111, 5, 5, 5, 0, 0, 0, 3'b001, 3'b000, 0);
        tbl[2]  = mk(3'b111, 5, 5, 5, 0, 0, 0, 3'b010, 3'b000, 0);
        tbl[3]  = mk(3'b111, 5, 5, 5, 0, 0, 0, 3'b100, 3'b001, D1);
        tbl[4]  = mk(3'b111, 5, 5, 5, 0, 0, 0, 3'b001, 3'b010, D1);
        tbl[5]  = mk(3'b111, 5, 5, 5, 0, 0, 0, 3'b010, 3'b100, D1);
        tbl[6]  = mk(3'b111, 5, 5, 5, 0, 0, 0, 3'b100, 3'b001, D1);
        tbl[7]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b010, D1);
        tbl[8]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b100, D1);
        tbl[9]  = mk(3'b110, 7, 1, 2, 0, 0, 0, 3'b010, 3'b000, 0);
        tbl[10] = mk(3'b110, 7, 1, 2, 0, 0, 0, 3'b100, 3'b000, 0);
        tbl[11] = mk(3'b110, 7, 1, 2, 0, 0, 0, 3'b010, 3'b010, INIT);
        tbl[12] = mk(3'b111, 7, 1, 2, 0, 0, 0, 3'b100, 3'b100, INIT);
        tbl[13] = mk(3'b111, 7, 1, 2, 0, 0, 0, 3'b001, 3'b010, INIT);
        tbl[14] = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b100, INIT);
        tbl[15] = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b001, INIT);
        tbl[16] = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);

        // Reset and init with a write held on the port that must be dropped
        reset = 1'b1;
        rd_req = 3'b111;
        rd_addr = '0;
        wen = 1'b1;
        waddr = 4'd3;
        wdata = 32'd1;
        #3;
        chk("reset_rdy", {31'd0, rdy}, 0);
        chk("reset_grant", {29'd0, rd_grant}, 0);
        chk("reset_rsp_valid", {29'd0, rsp_valid}, 0);
        #9;
        reset = 1'b0;
        wait_rdy("init");
        rd_req = 3'b000;
        wen = 1'b0;

        // Read every entry through requester 0
        for (int i = 0; i < 18; i++) begin
            cyc((i < 16) ? 3'b001 : 3'b000, 4'(i), 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, g, rv, rd, rvb, rdb);
            chk($sformatf("t1_grant%0d", i), {29'd0, g}, (i < 16) ? 32'd1 : 32'd0);
            chk($sformatf("t1_rsp_valid%0d", i), {29'd0, rv}, (i >= 2) ? 32'd1 : 32'd0);
            if (i >= 2) chk($sformatf("t1_rsp_data%0d", i), rd, INIT);
        end
        // One read by requester 2 moves the round-robin pointer back to 0
        cyc(3'b100, 0, 0, 0, 0, 0, 0, g, rv, rd, rvb, rdb);
        chk("t1_r2_grant", {29'd0, g}, 32'b100);
        cyc(3'b000, 0, 0, 0, 0, 0, 0, g, rv, rd, rvb, rdb);
        cyc(3'b000, 0, 0, 0, 0, 0, 0, g, rv, rd, rvb, rdb);
        chk("t1_r2_rsp_valid", {29'd0, rv}, 32'b100);
        chk("t1_r2_rsp_data", rd, INIT);

        // Round-robin vectors
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].req, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].we, tbl[i].wa, tbl[i].wd,
                g, rv, rd, rvb, rdb);
            chk($sformatf("tbl%0d_grant", i), {29'd0, g}, {29'd0, tbl[i].exp_g});
            chk($sformatf("tbl%0d_rsp_valid", i), {29'd0, rv}, {29'd0, tbl[i].exp_v});
            chk($sformatf("tbl%0d_rsp_valid_byp", i), {29'd0, rvb}, {29'd0, tbl[i].exp_v});
            if (tbl[i].exp_v != 0) begin
                chk($sformatf("tbl%0d_rsp_data", i), rd, tbl[i].exp_d);
                chk($sformatf("tbl%0d_rsp_data_byp", i), rdb, tbl[i].exp_d);
            end
        end

        // Read/write hazards
        cyc(3'b010, 0, 7, 0, 1, 7, 32'hDEAD_BEEF, g, rv, rd, rvb, rdb);
        chk("haz_c1_grant", {29'd0, g}, 32'b010);
        cyc(3'b010, 0, 7, 0, 0, 0, 0, g, rv, rd, rvb, rdb);
        chk("haz_c2_grant", {29'd0, g}, 32'b010);
        cyc(3'b001, 8, 0, 0, 0, 0, 0, g, rv, rd, rvb, rdb);
        chk("haz_c3_grant", {29'd0, g}, 32'b001);
        chk("haz_same_cycle_valid", {29'd0, rv}, 32'b010);
        chk("haz_same_cycle_data", rd, INIT);
        chk("haz_same_cycle_data_byp", rdb, 32'hDEAD_BEEF);
        cyc(3'b000, 0, 0, 0, 1, 8, 32'h0BAD_F00D, g, rv, rd, rvb, rdb);
        chk("haz_next_cycle_data", rd, 32'hDEAD_BEEF);
        chk("haz_next_cycle_data_byp", rdb, 32'hDEAD_BEEF);
        cyc(3'b001, 9, 0, 0, 0, 0, 0, g, rv, rd, rvb, rdb);
        chk("haz_c5_grant", {29'd0, g}, 32'b001);
        chk("haz_inflight_valid", {29'd0, rvb}, 32'b001);
        chk("haz_inflight_data", rd, INIT);
        chk("haz_inflight_data_byp", rdb, 32'h0BAD_F00D);
        cyc(3'b000, 0, 0, 0, 0, 0, 0, g, rv, rd, rvb, rdb);
        cyc(3'b000, 0, 0, 0, 1, 9, 32'h0F0F_0F0F, g, rv, rd, rvb, rdb);
        chk("haz_return_cycle_valid", {29'd0, rv}, 32'b001);
        chk("haz_return_cycle_data", rd, INIT);
        chk("haz_return_cycle_data_byp", rdb, INIT);
        cyc(3'b000, 0, 0, 0, 0, 0, 0, g, rv, rd, rvb, rdb);

        // Reset while a read is in flight
        cyc(3'b001, 7, 0, 0, 0, 0, 0, g, rv, rd, rvb, rdb);
        chk("rst_pre_grant", {29'd0, g}, 32'b001);
        rd_req = 3'b111;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_rsp_valid", {29'd0, rsp_valid}, 0);
        chk("rst_mid_rsp_valid_byp", {29'd0, rsp_valid_b}, 0);
        chk("rst_mid_rdy", {31'd0, rdy}, 0);
        chk("rst_mid_grant", {29'd0, rd_grant}, 0);
        @(posedge clk);
        #1;
        chk("rst_late_rsp_valid", {29'd0, rsp_valid}, 0);
        chk("rst_late_rsp_valid_byp", {29'd0, rsp_valid_b}, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_rdy("reinit");
        cyc(3'b001, 7, 0, 0, 0, 0, 0, g, rv, rd, rvb, rdb);
        chk("reinit_grant", {29'd0, g}, 32'b001);
        chk("reinit_no_stale_rsp", {29'd0, rv}, 0);
        cyc(3'b000, 0, 0, 0, 0, 0, 0, g, rv, rd, rvb, rdb);
        chk("reinit_no_stale_rsp2", {29'd0, rv}, 0);
        cyc(3'b000, 0, 0, 0, 0, 0, 0, g, rv, rd, rvb, rdb);
        chk("reinit_rsp_valid", {29'd0, rv}, 32'b001);
        chk("reinit_rsp_data", rd, INIT);
        chk("reinit_rsp_data_byp", rdb, INIT);

        // Random traffic against a reference memory and round-robin model
        for (int i = 0; i < NE; i++) ref_mem[i] = INIT;
        mptr = 1;
        rq = 3'b000;
        for (int i = 0; i < NR; i++) begin
            wcnt[i] = 0;
            ra[i] = 4'd0;
        end
        pv[0] = 1'b0; pv[1] = 1'b0;
        pidx[0] = 2'd0; pidx[1] = 2'd0;
        pd[0] = 32'd0; pd[1] = 32'd0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!rq[i] && $urandom_range(0, 1) == 1) begin
                    rq[i] = 1'b1;
                    ra[i] = 4'($urandom_range(0, NE - 1));
                end
            end
            we_r = ($urandom_range(0, 3) == 0);
            wa_r = 4'($urandom_range(0, NE - 1));
            wd_r = $urandom;
            ewin = -1;
            for (int k = 0; k < NR; k++) begin
                cand = (mptr + k) % NR;
                if (ewin < 0 && rq[cand]) ewin = cand;
            end
            eg = (ewin >= 0) ? (3'b001 << ewin) : 3'b000;
            cyc(rq, ra[0], ra[1], ra[2], we_r, wa_r, wd_r, g, rv, rd, rvb, rdb);
            chk("rand_grant", {29'd0, g}, {29'd0, eg});
            chk("rand_onehot", {31'd0, $onehot0(g)}, 1);
            chk("rand_rsp_valid", {29'd0, rv}, pv[1] ? (32'd1 << pidx[1]) : 32'd0);
            if (pv[1]) chk("rand_rsp_data", rd, pd[1]);
            pv[1] = pv[0]; pidx[1] = pidx[0]; pd[1] = pd[0];
            pv[0] = (ewin >= 0);
            pidx[0] = (ewin >= 0) ? 2'(ewin) : 2'd0;
            pd[0] = (ewin >= 0) ? ref_mem[ra[ewin]] : 32'd0;
            if (we_r) ref_mem[wa_r] = wd_r;
            if (ewin >= 0) mptr = (ewin + 1) % NR;
            for (int i = 0; i < NR; i++) begin
                if (g[i]) begin
                    n_tests++;
                    if (wcnt[i] > NR - 1) begin
                        n_fail++;
                        $display("FAIL rand_wait: requester %0d waited %0d cycles, expected at most %0d",
                                 i, wcnt[i] + 1, NR);
                    end
                    rq[i] = 1'b0;
                    wcnt[i] = 0;
                end else if (rq[i]) begin
                    wcnt[i]++;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
